// File: rtl/config_load_sequencer.sv
// Config latch bank write sequencer: one word per run slot, with
// setup / enable / hold phasing so no latch ever sees a moving bus.
module config_load_sequencer #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 45,
  parameter int IDX_W     = 6,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic [IDX_W-1:0]     io_start_idx,
  input  logic [IDX_W:0]       io_count,
  input  logic                 io_abort,
  input  logic                 io_word_valid,
  input  logic [DATA_W-1:0]    io_word_data,
  output logic                 io_word_ready,
  output logic [DATA_W-1:0]    io_d_in,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_err,
  output logic                 io_cfg_valid
);

  localparam int MAXC0 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAXC  = (MAXC0 > HOLD_CYC) ? MAXC0 : HOLD_CYC;
  localparam int CNT_W = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, ENABLE, HOLD, DONE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W:0]       rem;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_WORDS-1:0] written;
  logic [IDX_W+1:0]     end_idx;
  logic                 bad;

  // One extra bit keeps the range check free of wrap-around.
  assign end_idx = {2'b0, io_start_idx} + {1'b0, io_count};
  assign bad = (io_count == '0) ||
               (end_idx > (IDX_W+2)'(NUM_WORDS));
  assign io_cfg_valid = &written;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      rem           <= '0;
      cnt           <= '0;
      written       <= '0;
      io_d_in       <= '0;
      io_configs_en <= '0;
      io_word_ready <= 1'b0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
      io_err        <= 1'b0;
    end else begin
      io_done <= 1'b0;
      io_err  <= 1'b0;
      if (io_abort && state != IDLE) begin
        state         <= IDLE;
        cnt           <= '0;
        io_configs_en <= '0;
        io_word_ready <= 1'b0;
        io_busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (io_start && !io_abort) begin
              if (bad) begin
                io_err <= 1'b1;
              end else begin
                idx           <= io_start_idx;
                rem           <= io_count;
                state         <= LOAD;
                io_word_ready <= 1'b1;
                io_busy       <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (io_word_valid && io_word_ready) begin
              io_d_in       <= io_word_data;
              io_word_ready <= 1'b0;
              cnt           <= '0;
              state         <= SETUP;
            end
          end
          SETUP: begin
            if (cnt == CNT_W'(SETUP_CYC-1)) begin
              cnt           <= '0;
              io_configs_en <= {{(NUM_WORDS-1){1'b0}}, 1'b1} << idx;
              state         <= ENABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ENABLE: begin
            if (cnt == CNT_W'(EN_CYC-1)) begin
              cnt           <= '0;
              io_configs_en <= '0;
              state         <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (cnt == CNT_W'(HOLD_CYC-1)) begin
              cnt          <= '0;
              written[idx] <= 1'b1;
              idx          <= idx + 1'b1;
              rem          <= rem - 1'b1;
              if (rem == (IDX_W+1)'(1)) begin
                io_done <= 1'b1;
                state   <= DONE;
              end else begin
                io_word_ready <= 1'b1;
                state         <= LOAD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            io_busy <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_load_sequencer.sv
// Randomized scoreboard bench for config_load_sequencer:
// driver queues expected enable pulses, a negedge monitor retires them.
module tb_config_load_sequencer;

  localparam int NW = 45;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic [5:0]    io_start_idx;
  logic [6:0]    io_count;
  logic          io_abort;
  logic          io_word_valid;
  logic [31:0]   io_word_data;
  logic          io_word_ready;
  logic [31:0]   io_d_in;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
  logic          io_err;
  logic          io_cfg_valid;

  config_load_sequencer dut (
    .clk(clk), .reset(reset),
    .io_start(io_start), .io_start_idx(io_start_idx),
    .io_count(io_count), .io_abort(io_abort),
    .io_word_valid(io_word_valid), .io_word_data(io_word_data),
    .io_word_ready(io_word_ready), .io_d_in(io_d_in),
    .io_configs_en(io_configs_en), .io_busy(io_busy),
    .io_done(io_done), .io_err(io_err),
    .io_cfg_valid(io_cfg_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_pend = 0;
  int            err_pend = 0;
  int            cyc = 0;
  int            done_cyc = 0;
  int            en_cyc[NW];
  bit [NW-1:0]   model_w = '0;
  logic [NW-1:0] prev_en = '0;
  logic [31:0]   prev_d = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: retire one scoreboard entry per enable pulse
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (io_configs_en != '0) begin
        check("en_onehot", 64'($countones(io_configs_en)), 64'd1);
        check("d_stable_en", 64'(io_d_in), 64'(prev_d));
        if (prev_en == '0) begin
          if (q.size() == 0) begin
            check("unexpected_enable", 64'(io_configs_en), 64'd0);
          end else begin
            exp_t e;
            logic [NW-1:0] ee;
            e = q.pop_front();
            ee = '0;
            ee[e.idx] = 1'b1;
            check("en_index", 64'(io_configs_en), 64'(ee));
            check("en_data", 64'(io_d_in), 64'(e.data));
            en_cyc[e.idx] = cyc;
          end
        end
      end
      if (prev_en != '0 && io_configs_en == '0)
        check("d_hold", 64'(io_d_in), 64'(prev_d));
      if (io_done) begin
        check("done_expected", 64'(done_pend > 0), 64'd1);
        if (done_pend > 0) done_pend--;
        done_cyc = cyc;
      end
      if (io_err) begin
        check("err_expected", 64'(err_pend > 0), 64'd1);
        if (err_pend > 0) err_pend--;
      end
    end
    prev_en = io_configs_en;
    prev_d  = io_d_in;
  end

  task automatic run(input int s, input int n, input bit fixed,
                     input bit gaps, input int stall_k,
                     input int abort_k, input int reset_k,
                     output int t0);
    logic [31:0] dat[$];
    bit bad;
    bit stop;
    int t;
    bad = (n == 0) || (s + n > NW);
    @(posedge clk);
    #1;
    if (bad) begin
      err_pend++;
    end else begin
      for (int k = 0; k < n; k++) begin
        dat.push_back(fixed ? 32'(k + 32'hA000) : $urandom);
        q.push_back('{s + k, dat[k]});
      end
      done_pend++;
    end
    io_start = 1'b1;
    io_start_idx = s[5:0];
    io_count = n[6:0];
    t0 = cyc;
    @(posedge clk);
    #1;
    io_start = 1'b0;
    if (bad) begin
      repeat (2) @(negedge clk);
      check("bad_busy", 64'(io_busy), 64'd0);
      check("bad_err_seen", 64'(err_pend), 64'd0);
      return;
    end
    stop = 1'b0;
    for (int k = 0; k < n && !stop; k++) begin
      if (gaps) begin
        io_word_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      if (k == stall_k) begin
        io_word_valid = 1'b0;
        t = 0;
        do @(negedge clk); while (!io_word_ready && ++t < 50);
        check("stall_ready_rise", 64'(io_word_ready), 64'd1);
        for (int c = 0; c < 10; c++) begin
          io_start = (c == 0);
          io_count = '0;
          @(negedge clk);
          check("stall_ready", 64'(io_word_ready), 64'd1);
          check("stall_en", 64'(io_configs_en), 64'd0);
          check("stall_busy", 64'(io_busy), 64'd1);
        end
        io_start = 1'b0;
        io_word_valid = 1'b1;
        io_word_data = dat[k];
        @(posedge clk);
        #1;
        continue;
      end
      io_word_valid = 1'b1;
      io_word_data = dat[k];
      t = 0;
      forever begin
        @(negedge clk);
        if (abort_k >= 0 && io_configs_en[s + abort_k]) begin
          #1;
          q.delete();
          done_pend--;
          io_abort = 1'b1;
          @(posedge clk);
          #1;
          io_abort = 1'b0;
          io_word_valid = 1'b0;
          @(negedge clk);
          check("abort_en", 64'(io_configs_en), 64'd0);
          check("abort_busy", 64'(io_busy), 64'd0);
          check("abort_ready", 64'(io_word_ready), 64'd0);
          for (int j = 0; j < abort_k; j++) model_w[s + j] = 1'b1;
          stop = 1'b1;
          break;
        end
        if (reset_k >= 0 && io_configs_en[s + reset_k]) begin
          #1;
          reset = 1'b0;
          #1;
          check("rst_en", 64'(io_configs_en), 64'd0);
          check("rst_d_in", 64'(io_d_in), 64'd0);
          check("rst_busy", 64'(io_busy), 64'd0);
          check("rst_ready", 64'(io_word_ready), 64'd0);
          check("rst_cfg_valid", 64'(io_cfg_valid), 64'd0);
          q.delete();
          done_pend = 0;
          model_w = '0;
          io_word_valid = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          reset = 1'b1;
          stop = 1'b1;
          break;
        end
        if (io_word_ready) break;
        if (++t > 100) begin
          check("ready_timeout", 64'd1, 64'd0);
          stop = 1'b1;
          break;
        end
      end
      if (stop) break;
      @(posedge clk);
      #1;
    end
    io_word_valid = 1'b0;
    if (!stop) begin
      t = 0;
      while (io_busy && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("run_finish", 64'(io_busy), 64'd0);
      check("done_seen", 64'(done_pend), 64'd0);
      for (int j = 0; j < n; j++) model_w[s + j] = 1'b1;
    end
    repeat (2) @(negedge clk);
    check("cfg_valid", 64'(io_cfg_valid), 64'(&model_w));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b0;
    io_start = 1'b0;
    io_start_idx = '0;
    io_count = '0;
    io_abort = 1'b0;
    io_word_valid = 1'b0;
    io_word_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_en", 64'(io_configs_en), 64'd0);
    check("reset_d_in", 64'(io_d_in), 64'd0);
    check("reset_ready", 64'(io_word_ready), 64'd0);
    check("reset_busy", 64'(io_busy), 64'd0);
    check("reset_done", 64'(io_done), 64'd0);
    check("reset_err", 64'(io_err), 64'd0);
    check("reset_cfg_valid", 64'(io_cfg_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run(40, 6, 0, 0, -1, -1, -1, t0);
    run(0, 0, 0, 0, -1, -1, -1, t0);
    run(40, 5, 0, 0, -1, -1, -1, t0);

    run(0, NW, 1, 0, -1, -1, -1, t0);
    for (int k = 0; k < NW; k++)
      check($sformatf("en_cycle_%0d", k),
            64'(en_cyc[k] - t0), 64'(3 + 4 * k));
    check("done_cycle", 64'(done_cyc - t0), 64'd181);
    check("cfg_valid_full", 64'(io_cfg_valid), 64'd1);

    run(10, 6, 0, 0, 3, -1, -1, t0);
    run(0, 8, 0, 0, -1, 3, -1, t0);
    run(5, 4, 0, 0, -1, -1, -1, t0);

    for (int r = 0; r < 25; r++)
      run($urandom_range(0, 47), $urandom_range(0, 10),
          0, 1, -1, -1, -1, t0);

    run(20, 6, 0, 0, -1, -1, 2, t0);
    check("post_rst_cfg", 64'(io_cfg_valid), 64'd0);
    run(0, 3, 0, 0, -1, -1, -1, t0);

    repeat (4) @(negedge clk);
    check("final_done_pend", 64'(done_pend), 64'd0);
    check("final_err_pend", 64'(err_pend), 64'd0);
    check("final_queue", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
